// File: rtl/call_stack_pkg.sv
// Shared definitions for the DRFA call/return stack: default geometry and overflow policy encodings.
package call_stack_pkg;

  localparam int unsigned DRFA_PC_W        = 9;
  localparam int unsigned DRFA_FLAG_W      = 4;
  localparam int unsigned DRFA_STACK_DEPTH = 8;

  typedef enum logic {
    CS_OVF_REJECT = 1'b0,
    CS_OVF_WRAP   = 1'b1
  } cs_ovf_mode_e;

endpackage

// File: rtl/call_stack_if.sv
// Control-side bundle of the call stack; err_clr exists only when CALL_STACK_ERR_EN is defined.
interface call_stack_if
  import call_stack_pkg::*;
#(
  parameter int unsigned DEPTH  = DRFA_STACK_DEPTH,
  parameter int unsigned PC_W   = DRFA_PC_W,
  parameter int unsigned FLAG_W = DRFA_FLAG_W
) ();

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              push_en;
  logic              pop_en;
  logic [PC_W-1:0]   push_pc;
  logic [FLAG_W-1:0] push_flags;
  logic [PC_W-1:0]   top_pc;
  logic [FLAG_W-1:0] top_flags;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              err_ovf;
  logic              err_unf;
`ifdef CALL_STACK_ERR_EN
  logic              err_clr;

  modport master (
    output push_en, pop_en, push_pc, push_flags, err_clr,
    input  top_pc, top_flags, empty, full, count, err_ovf, err_unf
  );
  modport slave (
    input  push_en, pop_en, push_pc, push_flags, err_clr,
    output top_pc, top_flags, empty, full, count, err_ovf, err_unf
  );
`else
  modport master (
    output push_en, pop_en, push_pc, push_flags,
    input  top_pc, top_flags, empty, full, count, err_ovf, err_unf
  );
  modport slave (
    input  push_en, pop_en, push_pc, push_flags,
    output top_pc, top_flags, empty, full, count, err_ovf, err_unf
  );
`endif

endinterface

// File: rtl/call_stack_mem.sv
// Entry storage for the call stack: flop array, one synchronous write port, one asynchronous read port.
module call_stack_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 13,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/call_stack.sv
// Call/return stack: circular write pointer and occupancy control over call_stack_mem.
// Optional sticky error flags and err_clr are built when CALL_STACK_ERR_EN is defined.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int unsigned  DEPTH    = DRFA_STACK_DEPTH,
  parameter int unsigned  PC_W     = DRFA_PC_W,
  parameter int unsigned  FLAG_W   = DRFA_FLAG_W,
  parameter cs_ovf_mode_e OVF_MODE = CS_OVF_REJECT
) (
  input logic         clk,
  input logic         rst_n,
  call_stack_if.slave bus
);

  localparam int unsigned SP_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = PC_W + FLAG_W;

  logic [SP_W-1:0]  sp_q, sp_d, sp_inc, sp_dec, wr_addr;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ENT_W-1:0] rd_data;
  logic             wr_en, ovf_ev, unf_ev, is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign sp_inc   = (sp_q == SP_W'(DEPTH - 1)) ? '0 : sp_q + 1'b1;
  assign sp_dec   = (sp_q == '0) ? SP_W'(DEPTH - 1) : sp_q - 1'b1;

  always_comb begin
    sp_d    = sp_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_addr = sp_q;
    ovf_ev  = 1'b0;
    unf_ev  = 1'b0;
    if (bus.push_en && bus.pop_en && !is_empty) begin
      // replace-in-place: the slot just below sp is the current top
      wr_en   = 1'b1;
      wr_addr = sp_dec;
    end else if (bus.push_en) begin
      if (!is_full) begin
        wr_en   = 1'b1;
        sp_d    = sp_inc;
        count_d = count_q + 1'b1;
      end else begin
        ovf_ev = 1'b1;
        if (OVF_MODE == CS_OVF_WRAP) begin
          // when full, sp points at the oldest entry, so overwriting it keeps the newest DEPTH
          wr_en = 1'b1;
          sp_d  = sp_inc;
        end
      end
    end else if (bus.pop_en) begin
      if (!is_empty) begin
        sp_d    = sp_dec;
        count_d = count_q - 1'b1;
      end else begin
        unf_ev = 1'b1;
      end
    end
    if (!rst_n) wr_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_q    <= '0;
      count_q <= '0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
    end
  end

  call_stack_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W),
    .AW    (SP_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata ({bus.push_pc, bus.push_flags}),
    .raddr (sp_dec),
    .rdata (rd_data)
  );

  assign bus.top_pc    = is_empty ? '0 : rd_data[ENT_W-1:FLAG_W];
  assign bus.top_flags = is_empty ? '0 : rd_data[FLAG_W-1:0];
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.count     = count_q;

`ifdef CALL_STACK_ERR_EN
  logic err_ovf_q, err_ovf_d, err_unf_q, err_unf_d;

  always_comb begin
    err_ovf_d = err_ovf_q;
    err_unf_d = err_unf_q;
    if (bus.err_clr) begin
      err_ovf_d = 1'b0;
      err_unf_d = 1'b0;
    end
    if (ovf_ev) err_ovf_d = 1'b1;
    if (unf_ev) err_unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign bus.err_ovf = err_ovf_q;
  assign bus.err_unf = err_unf_q;
`else
  logic unused_ev;
  assign unused_ev   = ovf_ev ^ unf_ev;
  assign bus.err_ovf = 1'b0;
  assign bus.err_unf = 1'b0;
`endif

endmodule
